// File: rtl/adc_input_corrector_pkg.sv
// Shared definitions for the ADC input corrector and its DAC-side counterpart.
// Holds the gain-shift clamp, the offset-binary conversion and the peak FSM encoding.
package adc_input_corrector_pkg;

  typedef enum logic {
    PK_IDLE  = 1'b0,
    PK_ACCUM = 1'b1
  } peak_state_e;

  // Limit the gain shift so a full-scale sample always fits the output word.
  function automatic logic [7:0] clamp_shift(input logic [7:0] shift,
                                             input int in_width,
                                             input int out_width);
    int max_shift;
    max_shift = out_width - in_width;
    if (int'(shift) > max_shift) return 8'(max_shift);
    return shift;
  endfunction

  // Offset binary <-> two's complement is the same MSB flip in both directions.
  function automatic logic [31:0] offset_to_twos(input logic [31:0] raw,
                                                 input int width);
    return raw ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/adc_input_corrector_peak_window_detector.sv
// Tracks the largest sample magnitude over fixed windows of valid samples.
// state    | meaning
// PK_IDLE  | no valid sample seen since reset
// PK_ACCUM | accumulating the running peak of the current window
module peak_window_detector
  import adc_input_corrector_pkg::*;
#(
  parameter int IN_WIDTH   = 14,
  parameter int WINDOW_LEN = 4096
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                i_valid,
  input  logic [IN_WIDTH-1:0] i_mag,
  output logic [IN_WIDTH-1:0] o_peak,
  output logic                o_strobe
);

  localparam int CntW = $clog2(WINDOW_LEN + 1);

  peak_state_e         r_state;
  logic [CntW-1:0]     r_count;
  logic [IN_WIDTH-1:0] r_peak;
  logic [IN_WIDTH-1:0] r_peak_out;
  logic                r_strobe;
  logic [IN_WIDTH-1:0] w_max;

  assign w_max    = (i_mag > r_peak) ? i_mag : r_peak;
  assign o_peak   = r_peak_out;
  assign o_strobe = r_strobe;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= PK_IDLE;
      r_count    <= '0;
      r_peak     <= '0;
      r_peak_out <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        PK_IDLE: begin
          if (i_valid) begin
            r_peak  <= i_mag;
            r_count <= CntW'(1);
            r_state <= PK_ACCUM;
          end
        end
        PK_ACCUM: begin
          if (i_valid) begin
            // This sample completes the window: publish and restart from empty.
            if (r_count == CntW'(WINDOW_LEN - 1)) begin
              r_peak_out <= w_max;
              r_strobe   <= 1'b1;
              r_count    <= '0;
              r_peak     <= '0;
            end else begin
              r_peak  <= w_max;
              r_count <= r_count + CntW'(1);
            end
          end
        end
        default: r_state <= PK_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_input_corrector.sv
// Converts offset-binary ADC samples to gain-shifted two's complement for the DDC,
// with a held overload flag and a windowed peak-magnitude report.
module adc_input_corrector
  import adc_input_corrector_pkg::*;
#(
  parameter int IN_WIDTH    = 14,
  parameter int OUT_WIDTH   = 27,
  parameter int HOLD_CYCLES = 4800000,
  parameter int WINDOW_LEN  = 4096
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  ADC_DATA,
  input  logic                 ADC_OTR,
  input  logic                 ADC_VALID,
  input  logic [7:0]           shift,
  output logic [OUT_WIDTH-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 OVERLOAD,
  output logic [IN_WIDTH-1:0]  PEAK_OUT,
  output logic                 PEAK_STROBE
);

  localparam int OvlW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [IN_WIDTH-1:0]  r1_data;
  logic                 r1_otr;
  logic                 r1_valid;
  logic [7:0]           r1_shift;

  logic [IN_WIDTH-1:0]  r2_s;
  logic [IN_WIDTH-1:0]  r2_mag;
  logic                 r2_valid;
  logic                 r2_clip;
  logic [7:0]           r2_shift;

  logic [OUT_WIDTH-1:0] r3_data;
  logic                 r3_valid;

  logic [OvlW-1:0]      r_ovl_cnt;
  logic                 r_ovl;

  logic [31:0]          w_twos32;
  logic [IN_WIDTH-1:0]  w_s;
  logic [IN_WIDTH-1:0]  w_mag;
  logic                 w_clip;
  logic [7:0]           w_shift_eff;
  logic [OUT_WIDTH-1:0] w_ext;
  logic                 w_unused_hi;

  assign w_twos32    = offset_to_twos({{(32 - IN_WIDTH){1'b0}}, r1_data}, IN_WIDTH);
  assign w_s         = w_twos32[IN_WIDTH-1:0];
  assign w_unused_hi = ^w_twos32[31:IN_WIDTH];
  // Negating the most negative code wraps to 2^(IN_WIDTH-1), which is the correct unsigned magnitude.
  assign w_mag       = w_s[IN_WIDTH-1] ? (-w_s) : w_s;
  assign w_clip      = r1_valid & (r1_otr | (&r1_data) | ~(|r1_data));
  assign w_shift_eff = clamp_shift(r1_shift, IN_WIDTH, OUT_WIDTH);
  assign w_ext       = {{(OUT_WIDTH - IN_WIDTH){r2_s[IN_WIDTH-1]}}, r2_s};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r1_data  <= '0;
      r1_otr   <= 1'b0;
      r1_valid <= 1'b0;
      r1_shift <= '0;
      r2_s     <= '0;
      r2_mag   <= '0;
      r2_valid <= 1'b0;
      r2_clip  <= 1'b0;
      r2_shift <= '0;
      r3_data  <= '0;
      r3_valid <= 1'b0;
    end else begin
      r1_data  <= ADC_DATA;
      r1_otr   <= ADC_OTR;
      r1_valid <= ADC_VALID;
      r1_shift <= shift;
      r2_s     <= w_s;
      r2_mag   <= w_mag;
      r2_valid <= r1_valid;
      r2_clip  <= w_clip;
      r2_shift <= w_shift_eff;
      r3_valid <= r2_valid;
      if (r2_valid) r3_data <= w_ext << r2_shift;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ovl_cnt <= '0;
      r_ovl     <= 1'b0;
    end else if (r2_clip) begin
      r_ovl_cnt <= OvlW'(HOLD_CYCLES - 1);
      r_ovl     <= 1'b1;
    end else if (r_ovl_cnt != '0) begin
      r_ovl_cnt <= r_ovl_cnt - OvlW'(1);
    end else begin
      r_ovl <= 1'b0;
    end
  end

  peak_window_detector #(
    .IN_WIDTH  (IN_WIDTH),
    .WINDOW_LEN(WINDOW_LEN)
  ) u_peak (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .i_valid (r2_valid),
    .i_mag   (r2_mag),
    .o_peak  (PEAK_OUT),
    .o_strobe(PEAK_STROBE)
  );

  assign DATA_OUT   = r3_data;
  assign DATA_VALID = r3_valid;
  assign OVERLOAD   = r_ovl;

endmodule

// File: doc/adc_input_corrector.md
Name: adc_input_corrector

Overview:
- Receive-side counterpart of the TX DAC output formatter.
- Captures raw offset-binary ADC samples and converts them to two's complement.
- Sign-extends and left-shifts each sample by a runtime gain shift into the wide signed DSP word feeding the DDC chain.
- Provides a retriggerable overload flag for clip indication and a windowed peak-magnitude report for RF gain control.

Parameters:
- in_width, 14, ADC sample width (offset binary)
- out_width, 27, output signed sample width; must exceed in_width
- hold_cycles, 4800000, clk_in cycles OVERLOAD stays asserted after the last clip
- window_len, 4096, valid samples per peak-measurement window

Ports:
- clk_in  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ADC_DATA  in  in_width  raw ADC sample, offset binary
- ADC_OTR  in  1  ADC out-of-range pin
- ADC_VALID  in  1  sample strobe, one clk_in cycle per sample
- shift  in  8  unsigned left-shift (gain) amount
- DATA_OUT  out  out_width  signed corrected sample
- DATA_VALID  out  1  qualifies DATA_OUT
- OVERLOAD  out  1  clip indicator, held
- PEAK_OUT  out  in_width  unsigned peak |sample| of the last completed window
- PEAK_STROBE  out  1  one-cycle pulse when PEAK_OUT updates

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous and active-low, reset_n.
- Reset: all outputs, pipeline registers, counters and the running peak clear to 0.
- Pipeline (3 stages, each advances every cycle; valid bit travels with data):
  - S1: register ADC_DATA, ADC_OTR, ADC_VALID and shift together, so a shift change takes effect on a sample boundary.
  - S2: invert the MSB to form the signed sample s.
  - S2: clip = valid & (ADC_OTR | raw == all-ones | raw == all-zeros).
  - S2: mag = |s| as in_width unsigned; -2^(in_width-1) yields 2^(in_width-1), no overflow.
  - S3: DATA_OUT = sign_extend(s) << shift_eff, where shift_eff = min(shift, out_width - in_width). No saturation is needed.
- Latency: ADC_VALID at cycle n gives DATA_VALID at n+3.
- DATA_OUT holds its last value while DATA_VALID = 0.
- Overload counter:
  - Any S2 clip loads the counter with hold_cycles-1 and sets OVERLOAD on the next edge.
  - Otherwise the counter decrements while nonzero; OVERLOAD clears on the edge where the counter is 0 and no clip is present.
  - A clip during hold retriggers to the full hold.
- Peak FSM, states IDLE, ACCUM:
  - IDLE -> ACCUM on the first valid S2 sample, which initializes the running peak and sets sample count = 1.
  - ACCUM: each valid sample updates peak = max(peak, mag) and increments the count.
  - When the count reaches window_len on a valid sample, PEAK_OUT receives the max including that sample, PEAK_STROBE pulses on the same edge, and the state returns to ACCUM with count 0 and peak 0.
  - Invalid cycles do not advance the count.
- Simultaneous clip and window end: both take effect; they are independent.
- reset_n asserted mid-window: the partial window is discarded; no PEAK_STROBE after release until a full window completes.

Decomposition:
- Shared package holds:
  - function clamp_shift(shift, in_width, out_width)
  - offset-to-two's-complement conversion (MSB invert), reusable by the DAC formatter's inverse
  - peak FSM state encoding
- Sub-module: peak_window_detector (FSM + counter + max register), instantiated once; the remainder stays flat.

Test Plan:
- Mid-scale: ADC_DATA=14'h2000, shift=0, single valid -> DATA_VALID 3 cycles later, DATA_OUT=0, OVERLOAD=0.
- Max positive with full gain: ADC_DATA=14'h3FFE, shift=13 -> DATA_OUT=8190<<13=67092480.
- Shift clamp: ADC_DATA=14'h3FFE, shift=200 -> same output as shift=13, no X or wrap.
- Clip and hold, with hold_cycles=10:
  - ADC_DATA=14'h0000 at t0 -> OVERLOAD rises at t0+3 and holds exactly 10 cycles.
  - Second clip mid-hold -> hold restarts.
  - ADC_OTR=1 with ADC_DATA=14'h2100 -> also sets OVERLOAD.
- Peak window, with window_len=8:
  - Samples 14'h2000 + {1,-5,3,-100,2,0,7,50} -> one PEAK_STROBE, PEAK_OUT=100.
  - Next window, all 14'h0000 -> PEAK_OUT=8192.
- Reset mid-window: reset_n low after 5 of 8 samples -> all outputs 0 immediately (asynchronous); next PEAK_STROBE only after 8 fresh valid samples.
